// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial pattern detector with overlap/non-overlap matching,
// a registered one-cycle match pulse and a saturating match counter.
module seq_detector_prog #(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 16,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               in,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               count_clr,
  output logic               out,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  logic [MAX_LEN-1:0] hist;
  logic [LEN_W-1:0]   fill;
  logic [MAX_LEN-1:0] pat;
  logic [LEN_W-1:0]   len;
  logic               ovl;

  logic [MAX_LEN-1:0] hist_sh;
  logic [LEN_W-1:0]   fill_inc;
  logic [MAX_LEN-1:0] mask;
  logic               hit;
  logic               cfg_ok;

  always_comb begin
    hist_sh  = {hist[MAX_LEN-2:0], in};
    fill_inc = (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);
    mask     = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len);
    end
    // Match is judged on the post-shift history; a cfg_load edge never matches.
    hit    = in_valid && !cfg_load && (fill_inc >= len) &&
             ((hist_sh & mask) == (pat & mask));
    cfg_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist        <= '0;
      fill        <= '0;
      pat         <= '1;
      len         <= LEN_W'(3);
      ovl         <= 1'b1;
      out         <= 1'b0;
      cfg_err     <= 1'b0;
      match_count <= '0;
    end else begin
      out     <= hit;
      cfg_err <= cfg_load && !cfg_ok;

      if (cfg_load) begin
        if (cfg_ok) begin
          pat  <= cfg_pattern;
          len  <= cfg_len;
          ovl  <= cfg_overlap;
          hist <= '0;
          fill <= '0;
        end
      end else if (in_valid) begin
        hist <= hist_sh;
        fill <= (hit && !ovl) ? '0 : fill_inc;
      end

      if (count_clr) begin
        match_count <= hit ? CNT_W'(1) : '0;
      end else if (hit && (match_count != '1)) begin
        match_count <= match_count + CNT_W'(1);
      end
    end
  end

endmodule
